wallace_mul_pipe: RTL and testbench

WALLACE_MUL_PIPE -- requirements
Module: wallace_mul_pipe

---
 rtl/wallace_mul_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_wallace_mul_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mul_pipe.sv
// -----------------------------------------------------------------------------
// wallace_mul_pipe
//
// Three-stage pipelined WIDTH x WIDTH multiplier built on a Wallace tree of
// 3:2 carry-save compressors. Handles unsigned and two's-complement operands,
// selected per operand pair.
//
//   S1 : partial-product generation (with sign-correction rows) plus the first
//        CSA levels of the Wallace tree.
//   S2 : remaining CSA levels, down to two rows (sum, carry).
//   S3 : final carry-propagate add into z.
//
// Handshake (both sides): a transfer happens at a rising clk edge where
// valid && ready are both high. valid must not depend on ready. Once the
// block raises out_valid it holds z and out_valid stable until out_ready is
// seen high. in_ready is combinational: clrn && !(out_valid && !out_ready).
//
// Ports
//   clk        in   rising-edge clock for all state
//   clrn       in   synchronous active-low reset
//   in_valid   in   producer offers (a, b, sign_mode)
//   in_ready   out  block accepts the offer this cycle
//   a          in   [WIDTH-1:0]   multiplicand
//   b          in   [WIDTH-1:0]   multiplier
//   sign_mode  in   0 = unsigned, 1 = two's complement (ignored if !SIGNED_EN)
//   out_valid  out  z holds a valid product
//   out_ready  in   consumer takes the product this cycle
//   z          out  [2*WIDTH-1:0] product
//   busy       out  some pipeline stage holds a valid item
//
// Parameters
//   WIDTH      operand width, 4..32
//   SIGNED_EN  1: honour sign_mode; 0: always unsigned
// -----------------------------------------------------------------------------
module wallace_mul_pipe #(
   parameter int WIDTH     = 24,
   parameter int SIGNED_EN = 1
) (
   input  logic                 clk,
   input  logic                 clrn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 sign_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   z,
   output logic                 busy
);

   // --------------------------------------------------------------------------
   // Tree geometry
   // --------------------------------------------------------------------------
   localparam int ZW  = 2 * WIDTH;
   // One row per multiplier bit, plus one row carrying the +1 that completes
   // the two's-complement negation of the multiplier's sign-bit row.
   localparam int NPP = WIDTH + 1;

   typedef logic [ZW-1:0] row_t;
   typedef row_t          rows_t [NPP];

   // Row count after one Wallace level: every full group of three rows becomes
   // two, leftovers pass straight through.
   function automatic int next_rows(input int n);
      if (n <= 2) return n;
      return 2 * (n / 3) + (n % 3);
   endfunction

   function automatic int levels_to_two(input int n);
      int k;
      int c;
      k = n;
      c = 0;
      while (k > 2) begin
         k = next_rows(k);
         c = c + 1;
      end
      return c;
   endfunction

   function automatic int rows_after(input int n, input int lv);
      int k;
      k = n;
      for (int i = 0; i < lv; i++) k = next_rows(k);
      return k;
   endfunction

   localparam int NLEV   = levels_to_two(NPP);
   // S1 takes the first two levels; S2 takes the rest. For the legal width
   // range NLEV >= 3, so S2 always has at least one level.
   localparam int S1_LEV = (NLEV < 2) ? NLEV : 2;
   localparam int S2_LEV = NLEV - S1_LEV;
   localparam int N1     = rows_after(NPP, S1_LEV);

   // One Wallace level over the first n rows of r. Results are packed to the
   // low indices; rows beyond the new count are zero. All arithmetic is
   // modulo 2^ZW, which is exact for the final product.
   function automatic rows_t csa_level(input rows_t r, input int n);
      rows_t o;
      row_t  x;
      row_t  y;
      row_t  w;
      int    groups;
      int    rem;
      for (int i = 0; i < NPP; i++) o[i] = '0;
      groups = n / 3;
      rem    = n % 3;
      for (int g = 0; g < NPP / 3; g++) begin
         if (g < groups) begin
            x            = r[3*g];
            y            = r[3*g+1];
            w            = r[3*g+2];
            o[2*g]       = x ^ y ^ w;
            o[2*g+1]     = ((x & y) | (x & w) | (y & w)) << 1;
         end
      end
      for (int m = 0; m < 2; m++) begin
         if (m < rem) o[2*groups+m] = r[3*groups+m];
      end
      return o;
   endfunction

   // --------------------------------------------------------------------------
   // Pipeline control
   // --------------------------------------------------------------------------
   logic s1_valid;
   logic s2_valid;
   logic s3_valid;
   logic stall;
   logic accept;

   // The whole pipeline freezes while the output is held back; bubbles are
   // not squeezed out, which keeps ordering and hold behaviour trivial.
   assign stall     = s3_valid && !out_ready;
   assign in_ready  = clrn && !stall;
   assign accept    = in_valid && in_ready;
   assign out_valid = s3_valid;
   assign busy      = s1_valid || s2_valid || s3_valid;

   // --------------------------------------------------------------------------
   // S1 combinational: partial products and first CSA levels
   // --------------------------------------------------------------------------
   logic  sm_in;
   rows_t pp;
   rows_t s1_next;
   rows_t s1_rows;

   // sign_mode only shapes the partial products, so it is consumed here and
   // travels onward implicitly inside the captured rows.
   assign sm_in = (SIGNED_EN != 0) && sign_mode;

   always_comb begin : pp_gen
      row_t a_ext;
      a_ext = {{WIDTH{sm_in & a[WIDTH-1]}}, a};
      for (int i = 0; i < NPP; i++) pp[i] = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (b[i]) pp[i] = a_ext << i;
      end
      // Signed: the multiplier's top bit weighs -2^(WIDTH-1), so its row is
      // subtracted: -(x) = ~x + 1, the +1 going into the spare last row.
      if (sm_in && b[WIDTH-1]) begin
         pp[WIDTH-1] = ~(a_ext << (WIDTH-1));
         pp[WIDTH]   = row_t'(1);
      end
   end

   always_comb begin : s1_reduce
      rows_t r;
      int    n;
      r = pp;
      n = NPP;
      for (int l = 0; l < S1_LEV; l++) begin
         r = csa_level(r, n);
         n = next_rows(n);
      end
      s1_next = r;
   end

   // --------------------------------------------------------------------------
   // S2 combinational: finish the tree down to sum/carry
   // --------------------------------------------------------------------------
   row_t s2_sum_next;
   row_t s2_carry_next;
   row_t s2_sum;
   row_t s2_carry;

   // Rows of s1_rows at index >= N1 are always zero; they are kept in the
   // array only to share the row type with the tree function.
   always_comb begin : s2_reduce
      rows_t r;
      int    n;
      r = s1_rows;
      n = N1;
      for (int l = 0; l < S2_LEV; l++) begin
         r = csa_level(r, n);
         n = next_rows(n);
      end
      s2_sum_next   = r[0];
      s2_carry_next = r[1];
   end

   // --------------------------------------------------------------------------
   // Stage registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!clrn) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         for (int i = 0; i < NPP; i++) s1_rows[i] <= '0;
         s2_sum   <= '0;
         s2_carry <= '0;
         z        <= '0;
      end else if (!stall) begin
         s1_valid <= accept;
         if (accept) s1_rows <= s1_next;

         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sum   <= s2_sum_next;
            s2_carry <= s2_carry_next;
         end

         s3_valid <= s2_valid;
         if (s2_valid) z <= s2_sum + s2_carry;
      end
   end

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_wallace_mul_pipe
//
// Directed checks on a WIDTH=24 instance (reset, latency, signed corner
// products, backpressure, mid-flight reset) and randomized traffic against an
// arithmetic reference on WIDTH=24, 8 and 32 instances running side by side.
// -----------------------------------------------------------------------------
module tb_wallace_mul_pipe;

   localparam int N_RND     = 10000;
   localparam int RND_GUARD = 60000;

   // ---------------------------------------------------------------- clock
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference product: interpret operands as plain integers (signed when
   // s=1), multiply, keep 2*w bits.
   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input logic s, input int w);
      longint xv;
      longint yv;
      longint p;
      logic [63:0] mask;
      xv = longint'({32'd0, x});
      yv = longint'({32'd0, y});
      if (s && x[w-1]) xv = xv - (longint'(1) <<< w);
      if (s && y[w-1]) yv = yv - (longint'(1) <<< w);
      p = xv * yv;
      mask = (w == 32) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << (2 * w)) - 64'd1);
      return 64'(p) & mask;
   endfunction

   // ------------------------------------------------- directed DUT (W=24)
   logic        d_clrn;
   logic        d_iv;
   logic        d_ir;
   logic [23:0] d_a;
   logic [23:0] d_b;
   logic        d_sm;
   logic        d_ov;
   logic        d_ordy;
   logic [47:0] d_z;
   logic        d_busy;

   wallace_mul_pipe #(.WIDTH(24), .SIGNED_EN(1)) u_dut (
      .clk       (clk),
      .clrn      (d_clrn),
      .in_valid  (d_iv),
      .in_ready  (d_ir),
      .a         (d_a),
      .b         (d_b),
      .sign_mode (d_sm),
      .out_valid (d_ov),
      .out_ready (d_ordy),
      .z         (d_z),
      .busy      (d_busy)
   );

   // Offer one pair, then count edges until out_valid shows up.
   task automatic run_one(input string tag, input logic [23:0] x, input logic [23:0] y,
                          input logic s, input logic [47:0] exp);
      int lat;
      @(negedge clk);
      d_iv = 1'b1; d_a = x; d_b = y; d_sm = s; d_ordy = 1'b1;
      #1 check({tag, "_in_ready"}, 64'(d_ir), 64'd1);
      @(negedge clk);
      d_iv = 1'b0;
      lat = 1;
      while (!d_ov && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd3);
      check({tag, "_z"}, 64'(d_z), 64'(exp));
      @(negedge clk);
      check({tag, "_drained"}, 64'(d_ov), 64'd0);
   endtask

   // ------------------------------------------ random DUTs (W=24, 8, 32)
   for (genvar k = 0; k < 3; k++) begin : g_rnd
      localparam int W = (k == 0) ? 24 : ((k == 1) ? 8 : 32);

      logic           clrn;
      logic           iv;
      logic           ir;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           sm;
      logic           ov;
      logic           ordy;
      logic [2*W-1:0] z;
      logic           busy;
      logic           done;
      logic [2*W-1:0] exp_q[$];

      wallace_mul_pipe #(.WIDTH(W), .SIGNED_EN(1)) u_rnd (
         .clk       (clk),
         .clrn      (clrn),
         .in_valid  (iv),
         .in_ready  (ir),
         .a         (a),
         .b         (b),
         .sign_mode (sm),
         .out_valid (ov),
         .out_ready (ordy),
         .z         (z),
         .busy      (busy)
      );

      initial begin
         int             sent;
         int             got;
         int             guard;
         logic           stall_prev;
         logic [2*W-1:0] held_z;
         logic [2*W-1:0] e;
         done = 1'b0;
         clrn = 1'b0; iv = 1'b0; ordy = 1'b0; a = '0; b = '0; sm = 1'b0;
         repeat (3) @(negedge clk);
         clrn = 1'b1;
         sent = 0; got = 0; guard = 0; stall_prev = 1'b0; held_z = '0;
         while (got < N_RND && guard < RND_GUARD) begin
            @(negedge clk);
            guard++;
            if (stall_prev) begin
               check($sformatf("w%0d_hold_valid", W), 64'(ov), 64'd1);
               check($sformatf("w%0d_hold_z", W), 64'(z), 64'(held_z));
            end
            iv   = (sent < N_RND) ? 1'($urandom_range(0, 1)) : 1'b0;
            a    = W'($urandom);
            b    = W'($urandom);
            sm   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("w%0d_busy", W), 64'(busy), 64'(exp_q.size() != 0));
            check($sformatf("w%0d_in_ready", W), 64'(ir), 64'(!(ov && !ordy)));
            if (ov && ordy) begin
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check($sformatf("w%0d_z", W), 64'(z), 64'(e));
                  got++;
               end else begin
                  check($sformatf("w%0d_spurious_out", W), 64'(ov), 64'd0);
               end
            end
            stall_prev = ov && !ordy;
            held_z     = z;
            if (iv && ir) begin
               exp_q.push_back((2*W)'(ref_mul(32'(a), 32'(b), sm, W)));
               sent++;
            end
         end
         check($sformatf("w%0d_count_out", W), 64'(got), 64'(N_RND));
         check($sformatf("w%0d_count_in_eq_out", W), 64'(sent), 64'(got));
         check($sformatf("w%0d_queue_empty", W), 64'(exp_q.size()), 64'd0);
         done = 1'b1;
      end
   end

   // --------------------------------------------------------- main flow
   initial begin
      int cyc;
      d_clrn = 1'b0; d_iv = 1'b0; d_a = '0; d_b = '0; d_sm = 1'b0; d_ordy = 1'b0;

      // Reset state
      @(negedge clk);
      d_iv = 1'b1; d_a = 24'd5; d_b = 24'd5;
      #1 check("rst_in_ready_low", 64'(d_ir), 64'd0);
      @(negedge clk);
      check("rst_out_valid", 64'(d_ov), 64'd0);
      check("rst_busy", 64'(d_busy), 64'd0);
      check("rst_z", 64'(d_z), 64'd0);
      d_clrn = 1'b1; d_iv = 1'b0;
      @(negedge clk);
      check("post_rst_out_valid", 64'(d_ov), 64'd0);
      check("post_rst_busy", 64'(d_busy), 64'd0);
      check("post_rst_in_ready", 64'(d_ir), 64'd1);

      // Latency and corner products
      run_one("u_max",      24'hffffff, 24'hffffff, 1'b0, 48'hfffffe000001);
      run_one("s_m1m1",     24'hffffff, 24'hffffff, 1'b1, 48'h000000000001);
      run_one("s_min_max",  24'h800000, 24'h7fffff, 1'b1, 48'hc00000800000);
      run_one("s_min_min",  24'h800000, 24'h800000, 1'b1, 48'h400000000000);
      run_one("u_zero",     24'h000000, 24'h123456, 1'b0, 48'h000000000000);

      // Backpressure: three back-to-back pairs, consumer stalls 4 cycles
      @(negedge clk);
      d_ordy = 1'b0; d_sm = 1'b0;
      d_iv = 1'b1; d_a = 24'd2; d_b = 24'd3;
      @(negedge clk);
      d_a = 24'd4; d_b = 24'd5;
      @(negedge clk);
      d_a = 24'd6; d_b = 24'd7;
      @(negedge clk);
      d_iv = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("bp_stall%0d_valid", i), 64'(d_ov), 64'd1);
         check($sformatf("bp_stall%0d_z", i), 64'(d_z), 64'd6);
         check($sformatf("bp_stall%0d_in_ready", i), 64'(d_ir), 64'd0);
         @(negedge clk);
      end
      d_ordy = 1'b1;
      #1;
      check("bp_out0_valid", 64'(d_ov), 64'd1);
      check("bp_out0_z", 64'(d_z), 64'd6);
      @(negedge clk);
      check("bp_out1_valid", 64'(d_ov), 64'd1);
      check("bp_out1_z", 64'(d_z), 64'd20);
      @(negedge clk);
      check("bp_out2_valid", 64'(d_ov), 64'd1);
      check("bp_out2_z", 64'(d_z), 64'd42);
      @(negedge clk);
      check("bp_empty_valid", 64'(d_ov), 64'd0);
      check("bp_empty_busy", 64'(d_busy), 64'd0);

      // Reset with two items in flight; an offer during reset is refused
      d_iv = 1'b1; d_a = 24'd9; d_b = 24'd9; d_sm = 1'b0;
      @(negedge clk);
      d_a = 24'd11; d_b = 24'd13;
      @(negedge clk);
      d_a = 24'd3; d_b = 24'd3;
      d_clrn = 1'b0;
      #1 check("mid_rst_in_ready", 64'(d_ir), 64'd0);
      @(negedge clk);
      d_clrn = 1'b1; d_iv = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(d_ov), 64'd0);
      check("mid_rst_busy", 64'(d_busy), 64'd0);
      check("mid_rst_z", 64'(d_z), 64'd0);
      check("mid_rst_in_ready_back", 64'(d_ir), 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("mid_rst_no_stale%0d", i), 64'(d_ov), 64'd0);
      end

      // Wait for the random runs
      cyc = 0;
      while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && cyc < RND_GUARD + 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("random_runs_finished",
            64'(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
